light_share_arbiter: RTL and testbench
======================================

// Module: light_share_arbiter
// PURPOSE
//   Shares one timed-light power budget among N zones: at most one zone light is lit at a time.
//   Each zone has a push button; presses are latched as pending requests.
//   Requests are served round-robin: each grant lights one zone for a fixed on-time, then a guard gap follows.
//   Sits between the per-zone button inputs and the zone light drivers, replacing per-zone timer lights.
// PARAMETERS
//   N  4   number of zones (N >= 2); IW = $clog2(N) is local
//   T  20  on-time reload value; a grant lights its zone for exactly T+1 clock cycles
//   G  2   guard cycles with all lights off between grants (G >= 0; G=0 means no gap)
// PORTS
//   clock     in   1     clock; all state updates on rising edge
//   reset     in   1     reset, asynchronous, active-high
//   push_btn  in   N     per-zone request, level sampled at every rising edge
//   light     out  N     one-hot-or-zero zone light enables
//   busy      out  1     1 when state != IDLE
//   owner     out  IW    zone currently or last granted; meaningful while busy
//   pending   out  N     latched, not-yet-served requests (status)
// BEHAVIOUR
//   Reset (async): state=IDLE, pending=0, timer=0, gap counter=0, last=N-1 (zone 0 has first priority).
//     light=0 and busy=0 immediately on reset assertion; owner=N-1.
//   Outputs: light = (state==ON) ? onehot(owner) : 0. busy is decoded from the state. Both are combinational from registers, with no input-to-output path.
//   Pending: at each edge, pending[i] <= pending[i] | push_btn[i], except as noted below.
//     A press on an already-pending zone has no effect. A granted zone's bit clears on the grant edge.
//     A push on that edge is not re-latched.
//   FSM states: IDLE, ON, GAP.
//   IDLE: if pending != 0, pick the first set bit searching last+1, last+2, ... (mod N).
//     Set owner=last=pick, timer=T, clear pending[pick], then go to ON. Otherwise stay in IDLE.
//     Only registered pending bits arbitrate. A push sampled at edge E lights the zone after edge E+1.
//   ON: if timer==0, go to GAP with gap counter=G-1 (or to IDLE directly if G==0). Otherwise timer <= timer-1.
//   Retrigger: in ON, an owner push with no other pending bit set reloads timer=T; pending[owner] stays 0.
//     If any other zone is pending, the owner push instead sets pending[owner], to be served later in round-robin order.
//     A retrigger on the timer==0 edge reloads the timer and stays in ON.
//   GAP: all lights off for exactly G cycles. At gap counter==0, go to IDLE; otherwise decrement.
//     Pushes during GAP latch normally, including from the owner.
//   Round-robin is fair: a pending zone is served within N-1 grants.
//     Continuous retriggers can hold ON indefinitely only while no other zone is pending.
//   Widths: timer width is $clog2(T+1), minimum 1. The gap counter is sized for G, minimum 1. No wrap is possible.
// TESTING (N=4, T=3, G=2 unless stated)
//   1 push_btn=4'b0100 for 1 cycle at edge 0 -> pending[2]=1 after e0; light=0100 after e1..e4 (4 cycles);
//     light=0 and busy=1 after e5,e6; busy=0 after e7.
//   2 From reset, push_btn=4'b1001 for 1 cycle -> zone 0 lit 4 cycles, 2 gap cycles, then zone 3 lit 4 cycles;
//     pending goes 1001 -> 1000 -> 0000.
//   3 Round-robin: after zone 0 served, zones 0 and 1 pending -> zone 1 granted first, then zone 0.
//   4 Retrigger: zone 1 is lit; zone 1 pushes when timer==1 with no other requests -> light stays on 4 more cycles (5 total remaining);
//     repeat the same push while pending=0100 -> no reload, and pending becomes 0110.
//   5 Reset asserted mid-ON (light=0010) -> light=0, busy=0, pending=0 with no clock edge;
//     after release, a push on zone 3 is served normally.
//   6 G=0 build: pending zones 0 and 2 back-to-back -> light goes 0001 for 4 cycles, 0 for 1 cycle (IDLE arbitration), then 0100.

Source files
------------

// File: rtl/light_share_arbiter.sv
// light_share_arbiter: round-robin sharing of one timed light among N zones.
// Button presses latch into pending; one zone is lit at a time for T+1 cycles,
// followed by G all-off guard cycles before the next grant.
module light_share_arbiter #(
  parameter int N = 4,
  parameter int T = 20,
  parameter int G = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         push_btn,
  output logic [N-1:0]         light,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic [N-1:0]         pending
);

  localparam int IW = $clog2(N);
  localparam int TW = ($clog2(T + 1) < 1) ? 1 : $clog2(T + 1);
  localparam int GW = ($clog2(G + 1) < 1) ? 1 : $clog2(G + 1);
  localparam logic [TW-1:0] T_LOAD   = TW'(T);
  localparam logic [GW-1:0] GAP_LOAD = (G > 0) ? GW'(G - 1) : '0;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] last;
  logic [N-1:0]  pend_q;

  logic [IW-1:0] pick;
  logic          found;
  logic [N-1:0]  owner_mask;
  logic [N-1:0]  pick_mask;
  logic [N-1:0]  pend_in;
  logic          others;
  logic          retrig;

  // Rotating priority search starting just after the last granted zone.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && pend_q[IW'((int'(last) + k) % N)]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % N);
      end
    end
  end

  // Masks and the retrigger decision; only registered pending bits count as
  // competing requests, so a simultaneous press elsewhere does not block it.
  always_comb begin
    owner_mask = {{(N-1){1'b0}}, 1'b1} << last;
    pick_mask  = {{(N-1){1'b0}}, 1'b1} << pick;
    pend_in    = pend_q | push_btn;
    others     = |(pend_q & ~owner_mask);
    retrig     = (state == ON) && push_btn[last] && !others;
  end

  // Main FSM: request latching, grant, on-time countdown and guard gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      gap_cnt <= '0;
      last    <= IW'(N - 1);
      pend_q  <= '0;
    end else begin
      pend_q <= pend_in;
      case (state)
        IDLE: begin
          if (found) begin
            last   <= pick;
            timer  <= T_LOAD;
            pend_q <= pend_in & ~pick_mask;
            state  <= ON;
          end
        end
        ON: begin
          if (retrig) begin
            // Owner alone keeps the light: reload rather than queue itself.
            timer  <= T_LOAD;
            pend_q <= pend_in & ~owner_mask;
          end else if (timer == '0) begin
            if (G == 0) begin
              state <= IDLE;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registers; no input reaches them directly.
  always_comb begin
    light   = (state == ON) ? owner_mask : '0;
    busy    = (state != IDLE);
    owner   = last;
    pending = pend_q;
  end

endmodule

// File: tb/tb_light_share_arbiter.sv
// Directed bench for light_share_arbiter (N=4, T=3) with a G=2 build and a
// G=0 build side by side.
module tb_light_share_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] push_btn, push0;
  logic [3:0] light, pending, light0, pending0;
  logic [1:0] owner, owner0;
  logic       busy, busy0;

  int vec  = 0;
  int errs = 0;

  light_share_arbiter #(.N(4), .T(3), .G(2)) dut (
    .clock(clock), .reset(reset), .push_btn(push_btn),
    .light(light), .busy(busy), .owner(owner), .pending(pending)
  );

  light_share_arbiter #(.N(4), .T(3), .G(0)) dut0 (
    .clock(clock), .reset(reset), .push_btn(push0),
    .light(light0), .busy(busy0), .owner(owner0), .pending(pending0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset between edges; leaves the bench 3 time units past an edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vec++;
    if ({light, busy, owner, pending} !== {4'b0000, 1'b0, 2'd3, 4'b0000}) begin
      errs++;
      $display("FAIL reset_g2 got %b want %b", {light, busy, owner, pending}, {4'b0000, 1'b0, 2'd3, 4'b0000});
    end
    vec++;
    if ({light0, busy0, owner0, pending0} !== {4'b0000, 1'b0, 2'd3, 4'b0000}) begin
      errs++;
      $display("FAIL reset_g0 got %b want %b", {light0, busy0, owner0, pending0}, {4'b0000, 1'b0, 2'd3, 4'b0000});
    end
    #1;
    reset = 1'b0;
  endtask

  // Single request on zone 2: 4 lit cycles, 2 gap cycles, then idle.
  task automatic test_single();
    logic [8:0] exp [8] = '{9'b0000_0_0100, 9'b0100_1_0000, 9'b0100_1_0000, 9'b0100_1_0000,
                            9'b0100_1_0000, 9'b0000_1_0000, 9'b0000_1_0000, 9'b0000_0_0000};
    for (int i = 0; i < 8; i++) begin
      push_btn = (i == 0) ? 4'b0100 : 4'b0000;
      tick();
      push_btn = 4'b0000;
      vec++;
      if ({light, busy, pending} !== exp[i]) begin
        errs++;
        $display("FAIL single e%0d got %b want %b", i, {light, busy, pending}, exp[i]);
      end
    end
  endtask

  // Zones 0 and 3 together from reset: zone 0 first, then zone 3.
  task automatic test_two_zone();
    logic [8:0] exp [15] = '{9'b0000_0_1001,
                             9'b0001_1_1000, 9'b0001_1_1000, 9'b0001_1_1000, 9'b0001_1_1000,
                             9'b0000_1_1000, 9'b0000_1_1000, 9'b0000_0_1000,
                             9'b1000_1_0000, 9'b1000_1_0000, 9'b1000_1_0000, 9'b1000_1_0000,
                             9'b0000_1_0000, 9'b0000_1_0000, 9'b0000_0_0000};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      push_btn = (i == 0) ? 4'b1001 : 4'b0000;
      tick();
      push_btn = 4'b0000;
      vec++;
      if ({light, busy, pending} !== exp[i]) begin
        errs++;
        $display("FAIL two_zone e%0d got %b want %b", i, {light, busy, pending}, exp[i]);
      end
    end
  endtask

  // After zone 0 is served, zones 1 and 0 both pending: zone 1 wins next.
  task automatic test_round_robin();
    do_reset();
    push_btn = 4'b0001; tick(); push_btn = 4'b0000;
    tick();
    vec++;
    if ({light, owner} !== {4'b0001, 2'd0}) begin
      errs++; $display("FAIL rr_first got %b want %b", {light, owner}, {4'b0001, 2'd0});
    end
    push_btn = 4'b0010; tick();
    push_btn = 4'b0001; tick(); push_btn = 4'b0000;
    vec++;
    if ({light, pending} !== {4'b0001, 4'b0011}) begin
      errs++; $display("FAIL rr_queue got %b want %b", {light, pending}, {4'b0001, 4'b0011});
    end
    repeat (4) tick();
    vec++;
    if ({light, busy, pending} !== {4'b0000, 1'b0, 4'b0011}) begin
      errs++; $display("FAIL rr_idle got %b want %b", {light, busy, pending}, {4'b0000, 1'b0, 4'b0011});
    end
    tick();
    vec++;
    if ({light, owner, pending} !== {4'b0010, 2'd1, 4'b0001}) begin
      errs++; $display("FAIL rr_second got %b want %b", {light, owner, pending}, {4'b0010, 2'd1, 4'b0001});
    end
    repeat (7) tick();
    vec++;
    if ({light, owner, pending} !== {4'b0001, 2'd0, 4'b0000}) begin
      errs++; $display("FAIL rr_third got %b want %b", {light, owner, pending}, {4'b0001, 2'd0, 4'b0000});
    end
    repeat (6) tick();
  endtask

  // Owner retrigger reloads when alone; queues itself when another zone waits.
  task automatic test_retrigger();
    do_reset();
    push_btn = 4'b0010; tick(); push_btn = 4'b0000;
    tick(); tick(); tick();
    push_btn = 4'b0010; tick(); push_btn = 4'b0000;
    vec++;
    if ({light, pending} !== {4'b0010, 4'b0000}) begin
      errs++; $display("FAIL retrig_reload got %b want %b", {light, pending}, {4'b0010, 4'b0000});
    end
    push_btn = 4'b0100; tick(); push_btn = 4'b0000;
    vec++;
    if ({light, pending} !== {4'b0010, 4'b0100}) begin
      errs++; $display("FAIL retrig_other got %b want %b", {light, pending}, {4'b0010, 4'b0100});
    end
    push_btn = 4'b0010; tick(); push_btn = 4'b0000;
    vec++;
    if ({light, pending} !== {4'b0010, 4'b0110}) begin
      errs++; $display("FAIL retrig_queued got %b want %b", {light, pending}, {4'b0010, 4'b0110});
    end
    tick();
    vec++;
    if (light !== 4'b0010) begin
      errs++; $display("FAIL retrig_last_on got %b want %b", light, 4'b0010);
    end
    tick();
    vec++;
    if ({light, busy} !== {4'b0000, 1'b1}) begin
      errs++; $display("FAIL retrig_no_reload got %b want %b", {light, busy}, {4'b0000, 1'b1});
    end
    tick(); tick();
    vec++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL retrig_idle got %b want %b", busy, 1'b0);
    end
    tick();
    vec++;
    if ({light, owner, pending} !== {4'b0100, 2'd2, 4'b0010}) begin
      errs++; $display("FAIL retrig_next got %b want %b", {light, owner, pending}, {4'b0100, 2'd2, 4'b0010});
    end
  endtask

  // Async reset mid-ON clears outputs without an edge; zone 3 then serves normally.
  task automatic test_async_reset();
    do_reset();
    push_btn = 4'b0110; tick(); push_btn = 4'b0000;
    tick();
    vec++;
    if ({light, pending} !== {4'b0010, 4'b0100}) begin
      errs++; $display("FAIL areset_pre got %b want %b", {light, pending}, {4'b0010, 4'b0100});
    end
    #2 reset = 1'b1;
    #1;
    vec++;
    if ({light, busy, owner, pending} !== {4'b0000, 1'b0, 2'd3, 4'b0000}) begin
      errs++; $display("FAIL areset_now got %b want %b", {light, busy, owner, pending}, {4'b0000, 1'b0, 2'd3, 4'b0000});
    end
    #1 reset = 1'b0;
    push_btn = 4'b1000; tick(); push_btn = 4'b0000;
    vec++;
    if ({light, pending} !== {4'b0000, 4'b1000}) begin
      errs++; $display("FAIL areset_latch got %b want %b", {light, pending}, {4'b0000, 4'b1000});
    end
    tick();
    vec++;
    if ({light, busy, owner, pending} !== {4'b1000, 1'b1, 2'd3, 4'b0000}) begin
      errs++; $display("FAIL areset_serve got %b want %b", {light, busy, owner, pending}, {4'b1000, 1'b1, 2'd3, 4'b0000});
    end
  endtask

  // G=0 build: one idle arbitration cycle between back-to-back grants.
  task automatic test_back_to_back();
    logic [8:0] exp [11] = '{9'b0000_0_0101,
                             9'b0001_1_0100, 9'b0001_1_0100, 9'b0001_1_0100, 9'b0001_1_0100,
                             9'b0000_0_0100,
                             9'b0100_1_0000, 9'b0100_1_0000, 9'b0100_1_0000, 9'b0100_1_0000,
                             9'b0000_0_0000};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      push0 = (i == 0) ? 4'b0101 : 4'b0000;
      tick();
      push0 = 4'b0000;
      vec++;
      if ({light0, busy0, pending0} !== exp[i]) begin
        errs++;
        $display("FAIL b2b_g0 e%0d got %b want %b", i, {light0, busy0, pending0}, exp[i]);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    push_btn = 4'b0000;
    push0    = 4'b0000;
    #1;
    test_reset();
    tick();
    test_single();
    test_two_zone();
    test_round_robin();
    test_retrigger();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
